dmem_io_unit: RTL and testbench

//   Data-memory plus memory-mapped I/O slave for the PMIPSL0 16-bit pipelined core.

---
 rtl/pmips_pkg.sv | 16 +
 rtl/dmem_io_unit_if.sv | 14 +
 rtl/seven_seg_decoder.sv | 11 +
 rtl/dmem_io_unit.sv | 79 +++++++
 tb/tb_dmem_io_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pmips_pkg.sv
// Shared PMIPSL0 data-port definitions: word type, I/O register addresses and
// the 7-segment code table.
package pmips_pkg;

  typedef logic [15:0] word_t;

  localparam word_t DISP_ADDR = 16'hFFF0;
  localparam word_t SW_ADDR   = 16'hFFF8;

  // Index is the hex digit; bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/dmem_io_unit_if.sv
// Core data-memory port: byte address, write data, enables and combinational read data.
interface dmem_io_unit_if;
  import pmips_pkg::*;

  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  memwrite;
  logic  memread;

  modport master (output addr, output wdata, output memwrite, output memread, input rdata);
  modport slave  (input addr, input wdata, input memwrite, input memread, output rdata);

endinterface

// File: rtl/seven_seg_decoder.sv
// Hex digit to 7-segment pattern, purely combinational.
module seven_seg_decoder
  import pmips_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_CODES[digit_i];

endmodule

// File: rtl/dmem_io_unit.sv
// Data RAM plus memory-mapped display register and synchronized switch inputs
// for the PMIPSL0 data-memory port.
module dmem_io_unit
  import pmips_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_io_unit_if.slave        bus,
  input  logic                 io_sw0,
  input  logic                 io_sw1,
  output logic [6:0]           io_display
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  word_t          mem_q [MEM_WORDS];
  logic [3:0]     disp_q;
  logic [1:0]     sw_meta_q;
  logic [1:0]     sw_sync_q;
  word_t          rdata;

  logic           ram_sel;
  logic           disp_sel;
  logic           sw_sel;
  logic [AW-1:0]  ram_idx;
  logic           unused_addr0;

  // Full decode: anything above the RAM window that is not an I/O register reads zero.
  assign ram_sel      = word_t'(bus.addr >> (AW + 1)) == '0;
  assign disp_sel     = bus.addr[15:1] == DISP_ADDR[15:1];
  assign sw_sel       = bus.addr[15:1] == SW_ADDR[15:1];
  assign ram_idx      = bus.addr[AW:1];
  assign unused_addr0 = bus.addr[0];

  // RAM contents are deliberately left unreset; reset only blocks writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
    end else if (bus.memwrite && ram_sel) begin
      mem_q[ram_idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q    <= 4'h0;
      sw_meta_q <= 2'b00;
      sw_sync_q <= 2'b00;
    end else begin
      sw_meta_q <= {io_sw1, io_sw0};
      sw_sync_q <= sw_meta_q;
      if (bus.memwrite && disp_sel) begin
        disp_q <= bus.wdata[3:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.memread) begin
      if (ram_sel) begin
        rdata = mem_q[ram_idx];
      end else if (disp_sel) begin
        rdata = {12'b0, disp_q};
      end else if (sw_sel) begin
        rdata = {14'b0, sw_sync_q};
      end
    end
  end

  assign bus.rdata = rdata;

  seven_seg_decoder u_seg (
    .digit_i (disp_q),
    .seg_o   (io_display)
  );

endmodule

// File: tb/tb_dmem_io_unit.sv
// Directed bench for dmem_io_unit with a queue of expected values.
module tb_dmem_io_unit;
  import pmips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       sw0;
  logic       sw1;
  logic [6:0] display;

  int checks = 0;
  int errors = 0;
  word_t exp_q [$];
  string tag_q [$];

  logic [6:0] seg_ref [16];

  dmem_io_unit_if bus ();

  dmem_io_unit #(.MEM_WORDS(128)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .bus        (bus),
    .io_sw0     (sw0),
    .io_sw1     (sw1),
    .io_display (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input word_t value, input string tag);
    exp_q.push_back(value);
    tag_q.push_back(tag);
  endtask

  task automatic check(input word_t got);
    word_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, got, e);
    end
  endtask

  task automatic wr(input word_t a, input word_t d);
    @(negedge clk);
    bus.addr     = a;
    bus.wdata    = d;
    bus.memwrite = 1'b1;
    bus.memread  = 1'b0;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic rd(input word_t a, input word_t e, input string tag);
    @(negedge clk);
    expect_val(e, tag);
    bus.addr    = a;
    bus.memread = 1'b1;
    #1;
    check(bus.rdata);
    bus.memread = 1'b0;
  endtask

  task automatic chk_disp(input logic [6:0] e, input string tag);
    expect_val({9'b0, e}, tag);
    check({9'b0, display});
  endtask

  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n = 1'b0;
    sw0 = 1'b0;
    sw1 = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.memwrite = 1'b0;
    bus.memread = 1'b0;

    // Reset state, and a display write held across an edge during reset.
    #2;
    chk_disp(7'h3F, "reset_display");
    bus.addr = DISP_ADDR;
    bus.memread = 1'b1;
    expect_val(16'h0000, "reset_disp_read");
    #1;
    check(bus.rdata);
    bus.memread = 1'b0;
    wr(DISP_ADDR, 16'h0007);
    chk_disp(7'h3F, "write_during_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // RAM
    wr(16'h0010, 16'h1234);
    wr(16'h0012, 16'hBEEF);
    rd(16'h0010, 16'h1234, "ram_0010");
    rd(16'h0012, 16'hBEEF, "ram_0012");
    rd(16'h0011, 16'h1234, "ram_0011_odd");
    wr(16'h00FE, 16'h7E7E);
    rd(16'h00FE, 16'h7E7E, "ram_last_word");
    wr(16'h0000, 16'h0F0F);
    rd(16'h0000, 16'h0F0F, "ram_first_word");

    // Same-cycle read and write: old value before the edge, new after.
    wr(16'h0014, 16'h1111);
    @(negedge clk);
    bus.addr = 16'h0014;
    bus.wdata = 16'h2222;
    bus.memwrite = 1'b1;
    bus.memread = 1'b1;
    expect_val(16'h1111, "rw_before_edge");
    #1;
    check(bus.rdata);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    expect_val(16'h2222, "rw_after_edge");
    check(bus.rdata);
    bus.memread = 1'b0;

    // Display
    wr(DISP_ADDR, 16'h0005);
    chk_disp(7'h6D, "disp_5");
    wr(DISP_ADDR, 16'hFFFA);
    chk_disp(7'h77, "disp_A");
    rd(DISP_ADDR, 16'h000A, "disp_readback");
    rd(16'hFFF1, 16'h000A, "disp_readback_odd");
    for (int i = 0; i < 16; i++) begin
      wr(DISP_ADDR, word_t'(i));
      chk_disp(seg_ref[i], $sformatf("seg_%0h", i));
    end

    // Switches through the two-flop synchronizer.
    @(negedge clk);
    sw0 = 1'b1;
    sw1 = 1'b0;
    bus.addr = SW_ADDR;
    bus.memread = 1'b1;
    expect_val(16'h0000, "sw_edge0");
    #1;
    check(bus.rdata);
    @(posedge clk);
    #1;
    expect_val(16'h0000, "sw_edge1");
    check(bus.rdata);
    @(posedge clk);
    #1;
    expect_val(16'h0001, "sw_edge2");
    check(bus.rdata);
    bus.memread = 1'b0;
    wr(SW_ADDR, 16'hFFFF);
    rd(SW_ADDR, 16'h0001, "sw_write_ignored");
    @(negedge clk);
    sw0 = 1'b0;
    sw1 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    rd(SW_ADDR, 16'h0002, "sw1_only");

    // Unmapped and disabled accesses.
    wr(16'h4000, 16'h5555);
    rd(16'h4000, 16'h0000, "unmapped_4000");
    wr(16'h4010, 16'h6666);
    rd(16'h0010, 16'h1234, "no_alias_4010");
    wr(16'h0100, 16'h9999);
    rd(16'h0100, 16'h0000, "unmapped_0100");
    rd(16'h0000, 16'h0F0F, "no_alias_0100");
    rd(16'hFFF4, 16'h0000, "unmapped_fff4");
    rd(16'h0010, 16'h1234, "disabled_setup");
    @(negedge clk);
    bus.memread = 1'b0;
    bus.addr = 16'h0010;
    expect_val(16'h0000, "memread0_ram");
    #1;
    check(bus.rdata);
    bus.addr = DISP_ADDR;
    expect_val(16'h0000, "memread0_disp");
    #1;
    check(bus.rdata);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_disp(7'h3F, "async_reset_display");
    bus.memread = 1'b1;
    bus.addr = SW_ADDR;
    expect_val(16'h0000, "async_reset_sw");
    #1;
    check(bus.rdata);
    rst_n = 1'b1;
    bus.memread = 1'b0;
    rd(16'h0010, 16'h1234, "ram_kept_0010");
    rd(16'h0012, 16'hBEEF, "ram_kept_0012");
    rd(DISP_ADDR, 16'h0000, "disp_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
